dp_controller: RTL
==================

Name: dp_controller

Overview:
- Multi-cycle control sequencer that issues ARM data-processing instructions into the CPU datapath (regfile, shifter, ALU, status register).
- Accepts one 32-bit instruction over a valid/ready handshake, decodes it, and drives every datapath select, enable and address.
- Reads back the datapath status word so conditional execution is evaluated against current NZCV flags.
- Sits between the fetch stage and the datapath.

Parameters:
NZCV_LSB, 28, bit position of V in status_out; N/Z/C/V occupy [NZCV_LSB+3:NZCV_LSB]

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept (high only in IDLE)
instr  input  32  ARM instruction word
status_out  input  32  datapath status register
done  output  1  one-cycle pulse: instruction retired, skipped or rejected
skipped  output  1  qualifies done: condition failed
illegal  output  1  qualifies done: unsupported encoding
A_addr, B_addr, shift_addr, w_addr  output  4 each  regfile ports
en_A, en_B, en_S, w_en, en_status  output  1 each  datapath register enables
wb_sel  output  1  always 0 (ALU writeback)
sel_A  output  1  1 = force ALU A operand to zero
sel_B  output  1  1 = imme_data, 0 = shifter output
sel_shift  output  1  1 = shift amount from register, 0 = shift_imme
shift_op  output  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
shift_imme  output  32  zero-extended imm5 shift amount
imme_data  output  32  rotated immediate
ALU_op  output  3  ADD 000, SUB 001, AND 010, ORR 011, EOR 100

Behaviour:
- Reset: state IDLE, ir cleared, all outputs 0 except instr_ready=1. Reset mid-operation aborts; no w_en/en_status asserted the following cycle.
- Accept: in IDLE, instr_valid&&instr_ready latches instr into ir. The condition is evaluated against status_out in that same cycle.
- Decode: illegal if ir[27:26]!=00 or opcode not in {AND 0000, EOR 0001, SUB 0010, ADD 0100, CMP 1010, ORR 1100, MOV 1101}. CMP with S=0 is also illegal.
- State transitions:
  - IDLE -> LOAD on accept (legal, condition passes).
  - IDLE -> SKIP on accept when the condition fails.
  - IDLE -> REJECT on accept when illegal.
  - LOAD -> EXEC; EXEC, SKIP, REJECT -> IDLE.
- LOAD (1 cycle): drives A_addr=Rn[19:16], B_addr=Rm[3:0], shift_addr=Rs[11:8], with en_A=en_B=en_S=1.
  - Operand select: if I=1, en_S is still 1 with shift_imme=0 and sel_shift=0.
  - If I=0 and bit4=1, sel_shift=1. If I=0 and bit4=0, shift_imme={27'b0, ir[11:7]}.
  - shift_op=ir[6:5].
- EXEC (1 cycle):
  - sel_B=I; imme_data = {24'b0, ir[7:0]} rotated right by 2*ir[11:8].
  - ALU_op from opcode; MOV = ADD with sel_A=1, CMP = SUB.
  - w_en=1, w_addr=Rd[15:12] for all opcodes except CMP.
  - en_status=S; done=1.
- SKIP/REJECT (1 cycle): done=1 plus skipped or illegal; no enables asserted.
- Latency: accept at cycle 0, done at cycle 2 (executed) or cycle 1 (skip/reject). Next accept is cycle 3, by which time status is updated.
- Rd=15 is written like any register; no PC semantics.
- Selects and addresses hold stable from LOAD through EXEC; all outputs are functions of state and ir only.

Optional Feature:
COND_EXEC_EN
- Defined: ir[31:28] is evaluated against NZCV using the standard ARM table (EQ..AL); 1111 is treated as fail.
- Undefined: the condition field is ignored, every legal instruction executes, and skipped stays 0.

Decomposition:
- Package dp_ctrl_pkg holds:
  - state enum {IDLE, LOAD, EXEC, SKIP, REJECT};
  - ALU_op, shift_op and ARM opcode localparams;
  - condition-code localparams.
- Sub-module cond_check: combinational NZCV + cond -> pass. Instantiated only under COND_EXEC_EN.

Test Plan:
- 0xE2811005 (ADD R1,R1,#5) -> LOAD: A_addr=1, en_A=1. EXEC: sel_B=1, imme_data=5, ALU_op=000, w_en=1, w_addr=1, en_status=0. done in cycle 2.
- 0xE3A004FF (MOV R0,#0xFF000000) -> imme_data=0xFF000000, sel_A=1, ALU_op=000, w_addr=0.
- 0xE1520003 (CMP R2,R3) -> A_addr=2, B_addr=3, ALU_op=001, en_status=1, w_en=0.
- 0xE0854716 (ADD R4,R5,R6,LSL R7) -> shift_addr=7, sel_shift=1, shift_op=00, B_addr=6, w_addr=4.
- status_out=0, instr 0x02811005 (ADDEQ) -> COND_EXEC_EN: done=1, skipped=1 at cycle 1, no enables. Without macro: executes as the first scenario.
- 0xE2E11005 (RSC) -> illegal=1, done=1 at cycle 1. rst asserted during EXEC -> next cycle IDLE, instr_ready=1, w_en=0.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the data-processing control sequencer: FSM states,
// ALU/shifter op codes, ARM opcodes, condition codes and decode helpers.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXEC   = 3'd2,
    SKIP   = 3'd3,
    REJECT = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;

  // CMP without S would have no architectural effect, so it is rejected.
  function automatic logic is_legal(input logic [1:0] cls, input logic [3:0] op,
                                    input logic s);
    logic op_ok;
    case (op)
      OP_AND, OP_EOR, OP_SUB, OP_ADD, OP_ORR, OP_MOV: op_ok = 1'b1;
      OP_CMP:                                         op_ok = s;
      default:                                        op_ok = 1'b0;
    endcase
    return (cls == 2'b00) && op_ok;
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB, OP_CMP: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_ORR:         return ALU_ORR;
      OP_EOR:         return ALU_EOR;
      default:        return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] ror_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [31:0] v;
    logic [4:0]  sh;
    v  = {24'b0, imm8};
    sh = {rot, 1'b0};
    return (v >> sh) | (v << (6'd32 - {1'b0, sh}));
  endfunction

endpackage

// File: rtl/dp_controller_cond_check.sv
// ARM condition evaluation: NZCV flags + 4-bit cond field -> pass.
// The 1111 (NV) encoding always fails.
module cond_check
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_controller.sv
// Sequencer issuing one ARM data-processing instruction into the datapath
// (IDLE -> LOAD -> EXEC, or SKIP/REJECT). Conditional execution under COND_EXEC_EN.
module dp_controller
  import dp_ctrl_pkg::*;
#(
  parameter int NZCV_LSB = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] status_out,
  output logic        done,
  output logic        skipped,
  output logic        illegal,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic [3:0]  w_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        w_en,
  output logic        en_status,
  output logic        wb_sel,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_shift,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op
);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        in_legal, cond_pass;
  logic        unused_bits;

  assign in_legal = is_legal(instr[27:26], instr[24:21], instr[20]);

`ifdef COND_EXEC_EN
  cond_check u_cond (
    .cond (instr[31:28]),
    .nzcv (status_out[NZCV_LSB+3 -: 4]),
    .pass (cond_pass)
  );
`else
  assign cond_pass = 1'b1;
`endif

  // Condition and class bits are consumed at accept time, not from ir.
  assign unused_bits = ^{ir_q[31:26], status_out};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        ir_d = instr;
        if (!in_legal)       state_d = REJECT;
        else if (!cond_pass) state_d = SKIP;
        else                 state_d = LOAD;
      end
      LOAD:    state_d = EXEC;
      default: state_d = IDLE;
    endcase
  end

  logic       i_bit, s_bit, drive_dp;
  logic [3:0] opcode;
  assign i_bit  = ir_q[25];
  assign opcode = ir_q[24:21];
  assign s_bit  = ir_q[20];

  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    illegal     = 1'b0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_S        = 1'b0;
    w_en        = 1'b0;
    en_status   = 1'b0;
    wb_sel      = 1'b0;
    drive_dp    = 1'b0;
    A_addr      = '0;
    B_addr      = '0;
    shift_addr  = '0;
    w_addr      = '0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    sel_shift   = 1'b0;
    shift_op    = '0;
    shift_imme  = '0;
    imme_data   = '0;
    ALU_op      = '0;
    case (state_q)
      IDLE: instr_ready = 1'b1;
      LOAD: begin
        drive_dp = 1'b1;
        en_A     = 1'b1;
        en_B     = 1'b1;
        en_S     = 1'b1;
      end
      EXEC: begin
        drive_dp  = 1'b1;
        w_en      = (opcode != OP_CMP);
        en_status = s_bit;
        done      = 1'b1;
      end
      SKIP: begin
        done    = 1'b1;
        skipped = 1'b1;
      end
      REJECT: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
    // Selects and addresses stay put across LOAD and EXEC so the datapath
    // sees a stable operand path for the whole instruction.
    if (drive_dp) begin
      A_addr     = ir_q[19:16];
      B_addr     = ir_q[3:0];
      shift_addr = ir_q[11:8];
      w_addr     = ir_q[15:12];
      shift_op   = ir_q[6:5];
      sel_shift  = !i_bit && ir_q[4];
      if (!i_bit && !ir_q[4]) shift_imme = {27'b0, ir_q[11:7]};
      sel_B      = i_bit;
      sel_A      = (opcode == OP_MOV);
      imme_data  = ror_imm(ir_q[7:0], ir_q[11:8]);
      ALU_op     = alu_op_of(opcode);
    end
  end

endmodule
